wots_pk_from_sig_ctrl: RTL and testbench

Sequencer that drives `gen_chain_with_sha` as initiator to recover a WOTS+ public key from a signature. It decomposes a 256-bit message digest into base-w digits and appends the checksum digits. For each of the `WOTS_LEN` chains, it:
- reads the signature chunk from a memory port,
- sets the chain field of the hash address,
- starts the chain engine at the digit value and waits for its done,
- writes the result into a public-key memory port.

It sits between the XMSS verify top level and the chain engine.

---
 rtl/wots_pk_from_sig_ctrl.sv | 153 +++++++++++++++
 tb/tb_wots_pk_from_sig_ctrl.sv | 564 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wots_pk_from_sig_ctrl.sv
// WOTS+ public-key-from-signature sequencer: derives base-w digits plus checksum
// from a digest and runs one chain-engine job per signature chunk.
module wots_pk_from_sig_ctrl #(
   parameter int WOTS_W     = 16,
   parameter int WOTS_LOG_W = 4,
   parameter int WOTS_LEN1  = 64,
   parameter int WOTS_LEN2  = 3,
   parameter int WOTS_LEN   = 67,
   parameter int KEY_LEN    = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [255:0]          msg,
   input  logic [255:0]          base_addr,
   output logic                  busy,
   output logic                  done,
   output logic [6:0]            sig_addr,
   input  logic [KEY_LEN-1:0]    sig_rdata,
   output logic                  pk_we,
   output logic [6:0]            pk_addr,
   output logic [KEY_LEN-1:0]    pk_wdata,
   output logic                  chain_start,
   output logic [KEY_LEN-1:0]    chain_input_data,
   output logic [255:0]          chain_hash_addr,
   output logic [WOTS_LOG_W-1:0] chain_start_step,
   output logic [WOTS_LOG_W-1:0] chain_end_step,
   input  logic                  chain_done,
   input  logic [KEY_LEN-1:0]    chain_data_out
);

   localparam int CSUM_W = WOTS_LEN2 * WOTS_LOG_W;
   localparam logic [6:0] LAST_MSG   = 7'(WOTS_LEN1 - 1);
   localparam logic [6:0] LAST_CHAIN = 7'(WOTS_LEN - 1);
   localparam logic [WOTS_LOG_W-1:0] MAX_DIGIT = {WOTS_LOG_W{1'b1}};
   localparam logic [WOTS_LOG_W-1:0] END_STEP  = (WOTS_LOG_W)'(WOTS_W - 2);

   typedef enum logic [2:0] {
      IDLE, CSUM, READ, LOAD, START, WAIT, WRITE, DONE
   } state_t;

   state_t                  state, state_next;
   logic [255:0]            msg_r;
   logic [255:0]            addr_r;
   logic [CSUM_W-1:0]       csum;
   logic [6:0]              idx;
   logic [KEY_LEN-1:0]      data_r;
   logic [WOTS_LOG_W-1:0]   digit;
   logic                    unused_chain_field;

   // The chain field of the latched address is replaced by the chain index.
   assign unused_chain_field = ^addr_r[95:64];

   // Checksum digits sit at indices 64..66, so idx[1:0] picks csum nibble 0..2 MSB first.
   always_comb begin
      if (idx < 7'(WOTS_LEN1)) begin
         digit = msg_r[8'd255 - {idx[5:0], 2'b00} -: WOTS_LOG_W];
      end else begin
         digit = csum[4'(CSUM_W - 1) - {idx[1:0], 2'b00} -: WOTS_LOG_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         msg_r  <= '0;
         addr_r <= '0;
         csum   <= '0;
         idx    <= '0;
         data_r <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  msg_r  <= msg;
                  addr_r <= base_addr;
                  csum   <= '0;
                  idx    <= '0;
               end
            end
            CSUM: begin
               csum <= csum + CSUM_W'(MAX_DIGIT - digit);
               idx  <= (idx == LAST_MSG) ? 7'd0 : idx + 7'd1;
            end
            LOAD:  data_r <= sig_rdata;
            WAIT:  if (chain_done) data_r <= chain_data_out;
            WRITE: if (idx != LAST_CHAIN) idx <= idx + 7'd1;
            default: ;
         endcase
      end
   end

   // Outputs are decoded purely from state so a reset clears them immediately.
   always_comb begin
      state_next       = state;
      busy             = 1'b0;
      done             = 1'b0;
      sig_addr         = '0;
      pk_we            = 1'b0;
      pk_addr          = '0;
      pk_wdata         = '0;
      chain_start      = 1'b0;
      chain_input_data = '0;
      chain_hash_addr  = '0;
      chain_start_step = '0;
      chain_end_step   = '0;
      case (state)
         IDLE: if (start) state_next = CSUM;
         CSUM: begin
            busy = 1'b1;
            if (idx == LAST_MSG) state_next = READ;
         end
         READ: begin
            busy       = 1'b1;
            sig_addr   = idx;
            state_next = LOAD;
         end
         LOAD: begin
            busy       = 1'b1;
            state_next = (digit == MAX_DIGIT) ? WRITE : START;
         end
         START: begin
            busy        = 1'b1;
            chain_start = 1'b1;
            state_next  = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (chain_done) state_next = WRITE;
         end
         WRITE: begin
            busy       = 1'b1;
            pk_we      = 1'b1;
            pk_addr    = idx;
            pk_wdata   = data_r;
            state_next = (idx == LAST_CHAIN) ? DONE : READ;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (state == START || state == WAIT) begin
         chain_input_data = data_r;
         chain_hash_addr  = {addr_r[255:96], 25'd0, idx, addr_r[63:0]};
         chain_start_step = digit;
         chain_end_step   = END_STEP;
      end
   end

endmodule

// File: tb/tb_wots_pk_from_sig_ctrl.sv
// Bench for wots_pk_from_sig_ctrl: signature memory, a surrogate chain engine and
// an arithmetic WOTS pk_from_sig reference built from the digit/checksum rules.
module tb_wots_pk_from_sig_ctrl;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [255:0] msg, base_addr;
   logic         busy, done, pk_we, chain_start, chain_done;
   logic [6:0]   sig_addr, pk_addr;
   logic [255:0] sig_rdata, pk_wdata, chain_input_data, chain_hash_addr, chain_data_out;
   logic [3:0]   chain_start_step, chain_end_step;

   always #5 clk = ~clk;

   wots_pk_from_sig_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .msg(msg), .base_addr(base_addr),
      .busy(busy), .done(done), .sig_addr(sig_addr), .sig_rdata(sig_rdata),
      .pk_we(pk_we), .pk_addr(pk_addr), .pk_wdata(pk_wdata),
      .chain_start(chain_start), .chain_input_data(chain_input_data),
      .chain_hash_addr(chain_hash_addr), .chain_start_step(chain_start_step),
      .chain_end_step(chain_end_step), .chain_done(chain_done),
      .chain_data_out(chain_data_out)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Surrogate hash step and chain; stands in for SHA-based F in both engine and reference.
   function automatic logic [255:0] hstep(input logic [255:0] x, input logic [255:0] a, input int j);
      logic [255:0] r;
      r = {x[250:0], x[255:251]} ^ a;
      r = r + 256'(32'(j + 1) * 32'h9E3779B9);
      return r;
   endfunction

   function automatic logic [255:0] chain_fn(input logic [255:0] x, input int s, input int e,
                                             input logic [255:0] a);
      logic [255:0] r;
      r = x;
      for (int j = s; j <= e; j++) r = hstep(r, a, j);
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [793:0] all_outs();
      return {busy, done, sig_addr, pk_we, pk_addr, pk_wdata, chain_start, chain_input_data,
              chain_hash_addr, chain_start_step, chain_end_step};
   endfunction

   // Signature memory with one cycle read latency.
   logic [255:0] sig_mem [67];
   always @(posedge clk) sig_rdata <= (sig_addr < 7'd67) ? sig_mem[sig_addr] : '0;

   // Chain engine model: done is high eng_lat cycles after the start cycle.
   int           eng_lat = 10;
   bit           eng_rand = 1'b0;
   logic         inject = 1'b0;
   logic         eng_done;
   logic [255:0] eng_data, eng_res;
   int           eng_cnt;
   assign chain_done     = eng_done | inject;
   assign chain_data_out = inject ? {8{32'hDEADBEEF}} : eng_data;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         eng_done <= 1'b0;
         eng_cnt  <= 0;
         eng_data <= '0;
         eng_res  <= '0;
      end else begin
         eng_done <= 1'b0;
         if (chain_start) begin
            eng_cnt <= (eng_rand ? int'($urandom_range(6, 2)) : eng_lat) - 1;
            eng_res <= chain_fn(chain_input_data, int'(chain_start_step),
                                int'(chain_end_step), chain_hash_addr);
         end else if (eng_cnt == 1) begin
            eng_done <= 1'b1;
            eng_data <= eng_res;
            eng_cnt  <= 0;
         end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end

   // Event recorder
   int           wr_idx_q[$];
   logic [255:0] wr_dat_q[$];
   int           cs_idx_q[$], cs_step_q[$], cs_end_q[$];
   logic [255:0] cs_addr_q[$], cs_in_q[$];
   int           done_q[$];
   bit           done_busy_q[$];

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (pk_we) begin
            wr_idx_q.push_back(int'(pk_addr));
            wr_dat_q.push_back(pk_wdata);
         end
         if (chain_start) begin
            cs_idx_q.push_back(int'(chain_hash_addr[95:64]));
            cs_step_q.push_back(int'(chain_start_step));
            cs_end_q.push_back(int'(chain_end_step));
            cs_addr_q.push_back(chain_hash_addr);
            cs_in_q.push_back(chain_input_data);
         end
         if (done) begin
            done_q.push_back(cyc);
            done_busy_q.push_back(busy);
         end
      end
   end

   // Reference model
   int           exp_d [67];
   logic [255:0] exp_pk [67];
   int           exp_lat, exp_nstart;
   logic [255:0] cur_base;
   int           lat_meas, t0;
   bit           busy_after;

   task automatic build_ref(input logic [255:0] m, input logic [255:0] b);
      int csum;
      logic [255:0] a;
      csum = 0;
      for (int i = 0; i < 64; i++) begin
         exp_d[i] = int'((m >> (4 * (63 - i))) & 256'hF);
         csum += 15 - exp_d[i];
      end
      exp_d[64] = csum / 256;
      exp_d[65] = (csum / 16) % 16;
      exp_d[66] = csum % 16;
      exp_lat = 66;
      exp_nstart = 0;
      for (int i = 0; i < 67; i++) begin
         a = b;
         a[95:64] = i;
         if (exp_d[i] == 15) begin
            exp_pk[i] = sig_mem[i];
            exp_lat += 3;
         end else begin
            exp_pk[i] = chain_fn(sig_mem[i], exp_d[i], 14, a);
            exp_lat += 4 + eng_lat;
            exp_nstart++;
         end
      end
      cur_base = b;
   endtask

   task automatic fill_sig();
      for (int k = 0; k < 67; k++) sig_mem[k] = rnd256();
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic run_op(input logic [255:0] m, input logic [255:0] b, input bit quick);
      int n;
      @(negedge clk);
      #1;
      wr_idx_q.delete(); wr_dat_q.delete(); cs_idx_q.delete(); cs_step_q.delete();
      cs_end_q.delete(); cs_addr_q.delete(); cs_in_q.delete(); done_q.delete(); done_busy_q.delete();
      msg = m;
      base_addr = b;
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
      msg = rnd256();
      base_addr = rnd256();
      busy_after = busy;
      n = 0;
      while (!done && n < 20000) begin
         tick();
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL run_timeout: done not seen after %0d cycles, required within 20000", n);
      end
      lat_meas = cyc - t0 + 1;
      if (!quick) repeat (5) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; msg = '0; base_addr = '0;
      fill_sig();
      repeat (3) tick();
      checks++;
      if (all_outs() !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: busy=%b done=%b pk_we=%b chain_start=%b any=%b, required all 0",
                  busy, done, pk_we, chain_start, |all_outs());
      end
      start = 1'b1;
      msg = rnd256();
      tick();
      reset = 1'b0;
      start = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_with_reset: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_zero_msg();
      logic [255:0] b, a;
      fill_sig();
      eng_rand = 1'b1;
      b = rnd256();
      build_ref('0, b);
      run_op('0, b, 1'b0);
      checks++;
      if (wr_idx_q.size() != 67) begin
         errors++;
         $display("[TB] FAIL zero_wcount: got %0d writes, required 67", wr_idx_q.size());
      end
      for (int k = 0; k < 67; k++) begin
         checks++;
         if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k]) begin
            errors++;
            $display("[TB] FAIL zero_pk[%0d]: got %h, required %h", k, wr_dat_q[k], exp_pk[k]);
         end
      end
      checks++;
      if (cs_step_q.size() != 67) begin
         errors++;
         $display("[TB] FAIL zero_nstart: got %0d chain starts, required 67", cs_step_q.size());
      end
      for (int k = 0; k < cs_step_q.size() && k < 67; k++) begin
         a = b;
         a[95:64] = k;
         checks++;
         if (cs_step_q[k] != exp_d[k] || cs_end_q[k] != 14 || cs_addr_q[k] !== a ||
             cs_in_q[k] !== sig_mem[k]) begin
            errors++;
            $display("[TB] FAIL zero_chain[%0d]: step=%0d end=%0d addr_ok=%b in_ok=%b, required step=%0d end=14",
                     k, cs_step_q[k], cs_end_q[k], cs_addr_q[k] === a, cs_in_q[k] === sig_mem[k], exp_d[k]);
         end
      end
      checks++;
      if (cs_step_q.size() != 67 || cs_step_q[64] != 3 || cs_step_q[65] != 12 || cs_step_q[66] != 0) begin
         errors++;
         $display("[TB] FAIL zero_csum_digits: got %0d,%0d,%0d, required 3,12,0",
                  cs_step_q[64], cs_step_q[65], cs_step_q[66]);
      end
      checks++;
      if (done_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL zero_done_count: got %0d, required 1", done_q.size());
      end
   endtask

   task automatic test_all_f();
      logic [255:0] b;
      fill_sig();
      eng_rand = 1'b1;
      b = rnd256();
      build_ref({256{1'b1}}, b);
      run_op({256{1'b1}}, b, 1'b0);
      checks++;
      if (cs_idx_q.size() != 3) begin
         errors++;
         $display("[TB] FAIL allf_nstart: got %0d chain starts, required 3", cs_idx_q.size());
      end
      for (int k = 0; k < 3 && k < cs_idx_q.size(); k++) begin
         checks++;
         if (cs_idx_q[k] != 64 + k || cs_step_q[k] != 0) begin
            errors++;
            $display("[TB] FAIL allf_chain[%0d]: idx=%0d step=%0d, required idx=%0d step=0",
                     k, cs_idx_q[k], cs_step_q[k], 64 + k);
         end
      end
      for (int k = 0; k < 67; k++) begin
         checks++;
         if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k] ||
             (k < 64 && wr_dat_q[k] !== sig_mem[k])) begin
            errors++;
            $display("[TB] FAIL allf_pk[%0d]: got %h, required %h", k, wr_dat_q[k], exp_pk[k]);
         end
      end
   endtask

   task automatic test_pattern();
      logic [255:0] m, b;
      fill_sig();
      eng_rand = 1'b0;
      eng_lat = 10;
      m = {4{64'h0123456789ABCDEF}};
      b = rnd256();
      build_ref(m, b);
      run_op(m, b, 1'b0);
      checks++;
      if (busy_after !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pattern_busy_rise: got %b, required 1", busy_after);
      end
      checks++;
      if (lat_meas != exp_lat) begin
         errors++;
         $display("[TB] FAIL pattern_latency: got %0d cycles, required %0d", lat_meas, exp_lat);
      end
      checks++;
      if (cs_step_q.size() != exp_nstart) begin
         errors++;
         $display("[TB] FAIL pattern_nstart: got %0d, required %0d", cs_step_q.size(), exp_nstart);
      end
      checks++;
      if (cs_step_q.size() < 3 || cs_step_q[$-2] != 1 || cs_step_q[$-1] != 14 || cs_step_q[$] != 0) begin
         errors++;
         $display("[TB] FAIL pattern_csum_digits: got %0d,%0d,%0d, required 1,14,0",
                  cs_step_q[$-2], cs_step_q[$-1], cs_step_q[$]);
      end
      checks++;
      if (done_busy_q.size() != 1 || done_busy_q[0] != 1'b0) begin
         errors++;
         $display("[TB] FAIL pattern_done: pulses=%0d busy_at_done=%b, required 1 pulse with busy 0",
                  done_busy_q.size(), done_busy_q[0]);
      end
      for (int k = 0; k < 67; k++) begin
         checks++;
         if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k]) begin
            errors++;
            $display("[TB] FAIL pattern_pk[%0d]: got %h, required %h", k, wr_dat_q[k], exp_pk[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [255:0] m, b;
      eng_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         fill_sig();
         m = rnd256();
         b = rnd256();
         build_ref(m, b);
         run_op(m, b, 1'b0);
         checks++;
         if (cs_step_q.size() != exp_nstart || wr_idx_q.size() != 67) begin
            errors++;
            $display("[TB] FAIL random%0d_counts: starts=%0d writes=%0d, required %0d and 67",
                     r, cs_step_q.size(), wr_idx_q.size(), exp_nstart);
         end
         for (int k = 0; k < 67; k++) begin
            checks++;
            if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k]) begin
               errors++;
               $display("[TB] FAIL random%0d_pk[%0d]: got %h, required %h", r, k, wr_dat_q[k], exp_pk[k]);
            end
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [255:0] m, b;
      fill_sig();
      eng_rand = 1'b0;
      eng_lat = 10;
      m = rnd256();
      b = rnd256();
      build_ref(m, b);
      fork
         run_op(m, b, 1'b0);
         begin : disturb
            int n;
            n = 0;
            repeat (10) tick();
            start = 1'b1;
            msg = rnd256();
            tick();
            start = 1'b0;
            while (!chain_start && n < 3000) begin
               tick();
               n++;
            end
            repeat (2) tick();
            start = 1'b1;
            msg = rnd256();
            base_addr = rnd256();
            tick();
            start = 1'b0;
         end
      join
      checks++;
      if (wr_idx_q.size() != 67 || done_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL ignore_counts: writes=%0d dones=%0d, required 67 and 1",
                  wr_idx_q.size(), done_q.size());
      end
      checks++;
      if (lat_meas != exp_lat) begin
         errors++;
         $display("[TB] FAIL ignore_latency: got %0d, required %0d", lat_meas, exp_lat);
      end
      for (int k = 0; k < 67; k++) begin
         checks++;
         if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k]) begin
            errors++;
            $display("[TB] FAIL ignore_pk[%0d]: got %h, required %h", k, wr_dat_q[k], exp_pk[k]);
         end
      end
   endtask

   task automatic test_reset_wait();
      logic [255:0] m, b;
      int n;
      fill_sig();
      eng_rand = 1'b0;
      eng_lat = 10;
      m = '0;
      tick();
      msg = m;
      base_addr = rnd256();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(chain_start && chain_hash_addr[95:64] == 32'd20) && n < 5000) begin
         tick();
         n++;
      end
      repeat (2) tick();
      checks++;
      if (busy !== 1'b1 || n >= 5000) begin
         errors++;
         $display("[TB] FAIL rstwait_reach: busy=%b waited=%0d, required busy 1 in chain 20 wait", busy, n);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (all_outs() !== '0) begin
         errors++;
         $display("[TB] FAIL rstwait_outputs: busy=%b chain_start=%b pk_we=%b any=%b, required all 0",
                  busy, chain_start, pk_we, |all_outs());
      end
      tick();
      reset = 1'b0;
      tick();
      m = rnd256();
      b = rnd256();
      build_ref(m, b);
      run_op(m, b, 1'b0);
      checks++;
      if (wr_idx_q.size() != 67 || done_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL rstwait_counts: writes=%0d dones=%0d, required 67 and 1",
                  wr_idx_q.size(), done_q.size());
      end
      for (int k = 0; k < 67; k++) begin
         checks++;
         if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k]) begin
            errors++;
            $display("[TB] FAIL rstwait_pk[%0d]: got %h, required %h", k, wr_dat_q[k], exp_pk[k]);
         end
      end
   endtask

   task automatic test_spurious_done();
      logic [255:0] m, b;
      fill_sig();
      eng_rand = 1'b1;
      m = '0;
      b = rnd256();
      build_ref(m, b);
      fork
         run_op(m, b, 1'b0);
         begin : injector
            int n;
            n = 0;
            while (!(pk_we && pk_addr == 7'd5) && n < 5000) begin
               tick();
               n++;
            end
            tick();
            checks++;
            if (sig_addr !== 7'd6) begin
               errors++;
               $display("[TB] FAIL spur_in_read: sig_addr=%0d, required 6", sig_addr);
            end
            inject = 1'b1;
            tick();
            inject = 1'b0;
         end
      join
      checks++;
      if (wr_idx_q.size() != 67 || cs_step_q.size() != 67) begin
         errors++;
         $display("[TB] FAIL spur_counts: writes=%0d starts=%0d, required 67 and 67",
                  wr_idx_q.size(), cs_step_q.size());
      end
      for (int k = 0; k < 67; k++) begin
         checks++;
         if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k]) begin
            errors++;
            $display("[TB] FAIL spur_pk[%0d]: got %h, required %h", k, wr_dat_q[k], exp_pk[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] m1, m2, b;
      fill_sig();
      eng_rand = 1'b0;
      eng_lat = 10;
      m1 = rnd256();
      m2 = rnd256();
      b = rnd256();
      build_ref(m1, b);
      run_op(m1, b, 1'b1);
      for (int k = 0; k < 67; k++) begin
         checks++;
         if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k]) begin
            errors++;
            $display("[TB] FAIL b2b_first_pk[%0d]: got %h, required %h", k, wr_dat_q[k], exp_pk[k]);
         end
      end
      build_ref(m2, b);
      run_op(m2, b, 1'b0);
      checks++;
      if (busy_after !== 1'b1 || lat_meas != exp_lat) begin
         errors++;
         $display("[TB] FAIL b2b_second: busy_after=%b latency=%0d, required 1 and %0d",
                  busy_after, lat_meas, exp_lat);
      end
      for (int k = 0; k < 67; k++) begin
         checks++;
         if (k >= wr_idx_q.size() || wr_idx_q[k] != k || wr_dat_q[k] !== exp_pk[k]) begin
            errors++;
            $display("[TB] FAIL b2b_second_pk[%0d]: got %h, required %h", k, wr_dat_q[k], exp_pk[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_msg();
      test_all_f();
      test_pattern();
      test_random();
      test_start_ignored();
      test_reset_wait();
      test_spurious_done();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
